// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
// The FSM state encoding and digit constants are fixed here for the display/game interfaces.
package bcd_countdown_timer_pkg;

    localparam int unsigned BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Non-BCD nibbles (A..F) saturate to 9 on capture.
    function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the decrement chain: combinational borrow-in/borrow-out cell.
module bcd_digit_dec
    import bcd_countdown_timer_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    input  logic             borrow_in,
    output logic [BCD_W-1:0] digit_next,
    output logic             borrow_out,
    output logic             is_zero
);

    always_comb begin
        is_zero    = (digit == '0);
        borrow_out = borrow_in & is_zero;
        digit_next = digit;
        if (borrow_in) begin
            digit_next = is_zero ? BCD_MAX : (digit - 4'd1);
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with start/pause, tick divider and expiry outputs.
// Optional auto-reload on expiry is enabled by defining TIMER_AUTORELOAD_EN.
module bcd_countdown_timer
    import bcd_countdown_timer_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 2,
    parameter int unsigned TICK_DIV   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic [BCD_W*NUM_DIGITS-1:0] load_value,
    input  logic                        start,
    input  logic                        pause,
    input  logic                        tick,
    output logic [BCD_W*NUM_DIGITS-1:0] count,
    output logic                        running,
    output logic                        expired,
    output logic                        done_pulse,
    output logic                        led
);

    localparam int unsigned W = BCD_W * NUM_DIGITS;
    localparam logic [7:0] DIV_LAST = 8'(TICK_DIV - 1);

    state_t          state_q, state_d;
    logic [7:0]      div_q, div_d;
    logic [W-1:0]    count_q, count_d;
    logic            done_q, done_d;
    logic [W-1:0]    load_clamped;
    logic [W-1:0]    dec_value;
    logic [NUM_DIGITS:0]   borrow;
    logic [NUM_DIGITS-1:0] dig_zero;
    logic            count_zero;

`ifdef TIMER_AUTORELOAD_EN
    logic [W-1:0]    reload_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reload_q <= '0;
        end else if (load) begin
            reload_q <= load_clamped;
        end
    end
`endif

    // Borrow enters at digit 0 and ripples upward.
    assign borrow[0] = 1'b1;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit_dec u_dec (
            .digit      (count_q[g*BCD_W +: BCD_W]),
            .borrow_in  (borrow[g]),
            .digit_next (dec_value[g*BCD_W +: BCD_W]),
            .borrow_out (borrow[g+1]),
            .is_zero    (dig_zero[g])
        );
    end

    assign count_zero = &dig_zero;

    always_comb begin
        load_clamped = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            load_clamped[i*BCD_W +: BCD_W] = clamp_digit(load_value[i*BCD_W +: BCD_W]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (load) begin
            count_d = load_clamped;
            div_d   = '0;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !pause && !count_zero) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSE;
                    // A final borrow out means the count is already zero: never underflow.
                    end else if (tick && !borrow[NUM_DIGITS]) begin
                        if (div_q == DIV_LAST) begin
                            div_d   = '0;
                            count_d = dec_value;
                            if (dec_value == '0) begin
                                done_d = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
                                if (reload_q != '0) begin
                                    count_d = reload_q;
                                end else begin
                                    state_d = ST_DONE;
                                end
`else
                                state_d = ST_DONE;
`endif
                            end
                        end else begin
                            div_d = div_q + 8'd1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (start && !pause) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        count      = count_q;
        running    = (state_q == ST_RUN);
        expired    = (state_q == ST_DONE);
        done_pulse = done_q;
        led        = count_zero;
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer: one instance with TICK_DIV=1, one with TICK_DIV=3.
// Expectations follow TIMER_AUTORELOAD_EN when the macro is defined.
module tb_bcd_countdown_timer;

`ifdef TIMER_AUTORELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk, rst;
    logic       la, sa, pa, ta, lb, sb, pb, tb;
    logic [7:0] lva, lvb;
    logic [7:0] ca, cb;
    logic       ra, ea, da, leda, rb, eb, db, ledb;

    int n_chk = 0;
    int n_err = 0;

    bcd_countdown_timer #(.NUM_DIGITS(2), .TICK_DIV(1)) dut_a (
        .clk(clk), .rst(rst), .load(la), .load_value(lva), .start(sa), .pause(pa), .tick(ta),
        .count(ca), .running(ra), .expired(ea), .done_pulse(da), .led(leda)
    );

    bcd_countdown_timer #(.NUM_DIGITS(2), .TICK_DIV(3)) dut_b (
        .clk(clk), .rst(rst), .load(lb), .load_value(lvb), .start(sb), .pause(pb), .tick(tb),
        .count(cb), .running(rb), .expired(eb), .done_pulse(db), .led(ledb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then drop all strobes.
    task automatic cyc();
        @(posedge clk);
        #1;
        la = 0; sa = 0; pa = 0; ta = 0;
        lb = 0; sb = 0; pb = 0; tb = 0;
    endtask

    logic [7:0] seq [6];

    initial begin
        seq = '{8'h14, 8'h13, 8'h12, 8'h11, 8'h10, 8'h09};
        la = 0; sa = 0; pa = 0; ta = 0; lva = '0;
        lb = 0; sb = 0; pb = 0; tb = 0; lvb = '0;
        rst = 0;
        #1 rst = 1;
        #2;
        check_eq("rst_count", ca, 8'h00);
        check_eq("rst_led", leda, 1);
        check_eq("rst_running", ra, 0);
        check_eq("rst_expired", ea, 0);
        check_eq("rst_done", da, 0);
        @(negedge clk) rst = 0;

        // Basic countdown with borrow across digits.
        la = 1; lva = 8'h15; cyc();
        check_eq("load15", ca, 8'h15);
        check_eq("load15_idle", ra, 0);
        sa = 1; cyc();
        check_eq("start_run", ra, 1);
        for (int i = 0; i < 6; i++) begin
            ta = 1; cyc();
            check_eq($sformatf("dec_%0d", i), ca, seq[i]);
        end
        check_eq("run_running", ra, 1);
        check_eq("run_led", leda, 0);

        // Reaching zero.
        la = 1; lva = 8'h01; cyc();
        sa = 1; cyc();
        ta = 1; cyc();
        check_eq("zero_count", ca, AR ? 8'h01 : 8'h00);
        check_eq("zero_done", da, 1);
        check_eq("zero_expired", ea, !AR);
        check_eq("zero_running", ra, AR);
        check_eq("zero_led", leda, !AR);
        cyc();
        check_eq("done_one_cycle", da, 0);
        sa = 1; cyc();
        check_eq("done_start_ign", ra, AR);
        check_eq("done_still_exp", ea, !AR);

        // Clamping and zero load.
        la = 1; lva = 8'h3C; cyc();
        check_eq("clamp", ca, 8'h39);
        check_eq("clamp_exp_clr", ea, 0);
        la = 1; lva = 8'h00; cyc();
        sa = 1; cyc();
        check_eq("zero_start_ign", ra, 0);
        check_eq("zero_load_led", leda, 1);

        // load beats tick; start+pause from IDLE.
        la = 1; lva = 8'h60; cyc();
        sa = 1; cyc();
        la = 1; lva = 8'h50; ta = 1; cyc();
        check_eq("load_prio", ca, 8'h50);
        check_eq("load_to_idle", ra, 0);
        sa = 1; pa = 1; cyc();
        check_eq("start_pause_idle", ra, 0);
        sa = 1; cyc();
        ta = 1; cyc();
        check_eq("after_load_dec", ca, 8'h49);

        // Divided tick base, pause holds count and divider.
        lb = 1; lvb = 8'h10; cyc();
        sb = 1; cyc();
        tb = 1; cyc();
        tb = 1; cyc();
        check_eq("div_hold2", cb, 8'h10);
        tb = 1; cyc();
        check_eq("div_third", cb, 8'h09);
        pb = 1; cyc();
        check_eq("pause_run", rb, 0);
        for (int i = 0; i < 5; i++) begin
            tb = 1; cyc();
        end
        check_eq("pause_hold", cb, 8'h09);
        sb = 1; cyc();
        check_eq("resume", rb, 1);
        tb = 1; cyc();
        tb = 1; cyc();
        check_eq("resume_two", cb, 8'h09);
        tb = 1; cyc();
        check_eq("resume_third", cb, 8'h08);

        // Asynchronous reset mid-run.
        la = 1; lva = 8'h27; cyc();
        sa = 1; cyc();
        check_eq("pre_rst_count", ca, 8'h27);
        #2 rst = 1;
        #1;
        check_eq("async_count", ca, 8'h00);
        check_eq("async_led", leda, 1);
        check_eq("async_running", ra, 0);
        check_eq("async_done", da, 0);
        @(negedge clk) rst = 0;

        // Auto-reload (or plain expiry) from 02.
        la = 1; lva = 8'h02; cyc();
        sa = 1; cyc();
        ta = 1; cyc();
        check_eq("ar_first", ca, 8'h01);
        ta = 1; cyc();
        check_eq("ar_done", da, 1);
        check_eq("ar_count", ca, AR ? 8'h02 : 8'h00);
        check_eq("ar_running", ra, AR);
        check_eq("ar_expired", ea, !AR);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
